// File: rtl/fir_tap_serializer.sv
// Delay line of TAPS samples whose bit-planes are streamed one beat per
// sample bit, so each DA lane of GROUP taps sees one address per beat.
module fir_tap_serializer #(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 64,
  parameter int GROUP     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [TAPS-1:0]           out_bits,
  output logic [$clog2(DATA_W)-1:0] out_idx,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      primed
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int LANES = TAPS / GROUP;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(TAPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] tap_q  [TAPS];
  logic [DATA_W-1:0] snap_q [TAPS];
  logic              accept_s;
  logic [IDX_W-1:0]  idx_s;

  assign s_ready  = resetn && (state_q == IDLE) && !flush;
  assign accept_s = s_valid && s_ready;
  assign primed   = (count_q == FULL_CNT);

  // FSM next-state and beat sequencing
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = LOAD;
        else          state_d = IDLE;
      end
      LOAD: begin
        state_d = SHIFT;
        beat_d  = '0;
      end
      SHIFT: begin
        if (out_ready && (beat_q == LAST_BEAT)) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (out_ready) begin
          beat_d  = beat_q + IDX_W'(1);
        end else begin
          beat_d  = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // FSM state and beat registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Delay line and warm-up count; flush clears them without touching the frame in flight
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
      count_q <= '0;
    end else if (accept_s) begin
      tap_q[0] <= s_data;
      for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
      if (count_q != FULL_CNT) count_q <= count_q + CNT_W'(1);
    end
  end

  // Frame snapshot, taken only in LOAD
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < TAPS; k++) snap_q[k] <= '0;
    end else if (state_q == LOAD) begin
      for (int k = 0; k < TAPS; k++) snap_q[k] <= tap_q[k];
    end
  end

  assign idx_s = (MSB_FIRST != 0) ? (LAST_BEAT - beat_q) : beat_q;

  // Beat outputs; all zero outside SHIFT
  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_bits  = '0;
    if (state_q == SHIFT) begin
      out_valid = 1'b1;
      out_idx   = idx_s;
      out_first = (beat_q == '0);
      out_last  = (beat_q == LAST_BEAT);
      for (int g = 0; g < LANES; g++) begin
        for (int j = 0; j < GROUP; j++) begin
          out_bits[g*GROUP + j] = snap_q[g*GROUP + j][idx_s];
        end
      end
    end else begin
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_serializer.sv
// Directed bench: default-parameter instance driven by a vector table and
// corner-case sequences, plus a small MSB-first instance.
module tb_fir_tap_serializer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, s_valid, s_ready, out_ready, out_valid, out_first, out_last, primed;
  logic [15:0] s_data;
  logic [63:0] out_bits;
  logic [3:0]  out_idx;

  logic        b_flush, b_s_valid, b_s_ready, b_out_ready, b_out_valid;
  logic        b_out_first, b_out_last, b_primed;
  logic [7:0]  b_s_data;
  logic [15:0] b_out_bits;
  logic [2:0]  b_out_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_tap_serializer dut (
    .clk(clk), .resetn(resetn), .flush(flush), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .out_ready(out_ready), .out_valid(out_valid), .out_bits(out_bits),
    .out_idx(out_idx), .out_first(out_first), .out_last(out_last), .primed(primed)
  );

  fir_tap_serializer #(.DATA_W(8), .TAPS(16), .GROUP(4), .MSB_FIRST(1)) dut_b (
    .clk(clk), .resetn(resetn), .flush(b_flush), .s_valid(b_s_valid), .s_data(b_s_data),
    .s_ready(b_s_ready), .out_ready(b_out_ready), .out_valid(b_out_valid),
    .out_bits(b_out_bits), .out_idx(b_out_idx), .out_first(b_out_first),
    .out_last(b_out_last), .primed(b_primed)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        exp_hi;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for s_ready, then offer one sample for exactly one edge.
  task automatic do_accept(input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready_timeout", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Observe the 18 cycles following an acceptance edge with out_ready high.
  task automatic collect(input int fc, output logic [15:0] c0, output logic [15:0] c1,
                         output logic [15:0] c2, output logic hi, output logic [63:0] b0,
                         output int first_c, output int shape_err, output logic rdy_ok);
    int beat;
    c0 = '0; c1 = '0; c2 = '0; hi = 1'b0; b0 = '0;
    first_c = -1; shape_err = 0; rdy_ok = 1'b1; beat = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (out_idx != 4'(beat) || out_first != (beat == 0) || out_last != (beat == 15))
          shape_err++;
        c0[out_idx] = out_bits[0];
        c1[out_idx] = out_bits[1];
        c2[out_idx] = out_bits[2];
        hi = hi | (|out_bits[63:3]);
        if (out_idx == 4'd0) b0 = out_bits;
        beat++;
      end else if (out_bits != 64'd0 || out_idx != 4'd0 || out_first || out_last) begin
        shape_err++;
      end
      if (c == 17 && s_ready) rdy_ok = 1'b0;
      if (c == 18 && !s_ready) rdy_ok = 1'b0;
      flush = (c == fc);
    end
    if (beat != 16) shape_err++;
  endtask

  task automatic run_check(input string nm, input logic [15:0] d, input logic [15:0] e1,
                           input logic [15:0] e2, input logic ehi, input int fc,
                           output logic [63:0] b0);
    logic [15:0] c0, c1, c2;
    logic        hi, rdy;
    int          fcy, se;
    do_accept(d);
    collect(fc, c0, c1, c2, hi, b0, fcy, se, rdy);
    chk({nm, "_tap0"}, c0, d);
    chk({nm, "_tap1"}, c1, e1);
    chk({nm, "_tap2"}, c2, e2);
    chk({nm, "_tap_hi_nonzero"}, hi, ehi);
    chk({nm, "_latency"}, fcy, 2);
    chk({nm, "_shape"}, se, 0);
    chk({nm, "_ready_timing"}, rdy, 1'b1);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  initial begin
    logic [63:0] b0, held;
    logic [21:0] bexp;
    logic [15:0] c0, c1, c2;
    logic        hi, rdy;
    int          fcy, se, n, stall_err;

    vecs[0] = '{16'h8001, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{16'h1234, 16'h8001, 16'h0000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h1234, 16'h8001, 1'b0};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[4] = '{16'hA5C3, 16'h0000, 16'hFFFF, 1'b1};

    resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; out_ready = 1'b1;
    b_flush = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {s_ready, out_valid, primed, out_first, out_last, out_idx},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    chk("reset_bits", out_bits, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("release_ready", {s_ready, out_valid}, {1'b1, 1'b0});

    // MSB-first instance: 0x80 gives idx 7 first with bit 0 set, then zeros
    chk("msb_ready", {63'd0, b_s_ready}, 64'd1);
    b_s_valid = 1'b1;
    b_s_data  = 8'h80;
    @(posedge clk);
    #1 b_s_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("msb_load_idle", {63'd0, b_out_valid}, 64'd0);
      end else if (c <= 9) begin
        bexp = {1'b1, 3'(9 - c), (c == 2), (c == 9), ((c == 2) ? 16'h0001 : 16'h0000)};
        chk($sformatf("msb_beat_c%0d", c),
            {b_out_valid, b_out_idx, b_out_first, b_out_last, b_out_bits}, bexp);
      end else begin
        chk("msb_ready_after", {b_s_ready, b_out_valid}, {1'b1, 1'b0});
      end
    end

    // Table-driven single-sample frames
    for (int i = 0; i < 5; i++)
      run_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp1, vecs[i].exp2,
                vecs[i].exp_hi, -1, b0);
    chk("vec_not_primed", {63'd0, primed}, 64'd0);

    // Warm-up: 64 samples 1..64 after a flush
    do_flush();
    chk("flush_primed", {63'd0, primed}, 64'd0);
    for (int i = 1; i <= 64; i++) begin
      run_check($sformatf("warm%0d", i), 16'(i), 16'(i - 1), (i >= 2) ? 16'(i - 2) : 16'd0,
                (i >= 4), -1, b0);
      if (i == 63) chk("primed_at_63", {63'd0, primed}, 64'd0);
    end
    chk("primed_at_64", {63'd0, primed}, 64'd1);
    chk("warm64_beat0", b0, 64'hAAAA_AAAA_AAAA_AAAA);

    // Stall at beat 3 with s_valid held
    do_accept(16'h0010);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 4'd3) && n < 20);
    chk("stall_reach_beat3", {out_valid, out_idx}, {1'b1, 4'd3});
    out_ready = 1'b0;
    s_valid   = 1'b1;
    s_data    = 16'h0777;
    held      = out_bits;
    stall_err = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_idx != 4'd3 || out_bits != held || out_first || out_last || s_ready || !out_valid)
        stall_err++;
    end
    chk("stall_hold", stall_err, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_resume_idx", out_idx, 4'd4);
    n = 0;
    while (!s_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("stall_cycles_to_ready", n, 12);
    @(posedge clk);
    #1 s_valid = 1'b0;
    collect(-1, c0, c1, c2, hi, b0, fcy, se, rdy);
    chk("stall_next_tap0", c0, 16'h0777);
    chk("stall_next_tap1", c1, 16'h0010);

    // Flush with s_valid in IDLE drops the sample
    @(negedge clk);
    flush = 1'b1; s_valid = 1'b1; s_data = 16'h5555;
    #1 chk("flush_idle_not_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk);
    #1 begin flush = 1'b0; s_valid = 1'b0; end
    @(negedge clk);
    chk("flush_idle_no_frame", {s_ready, out_valid}, {1'b1, 1'b0});
    run_check("fl_a", 16'h0003, 16'h0000, 16'h0000, 1'b0, -1, b0);
    run_check("fl_b", 16'h0005, 16'h0003, 16'h0000, 1'b0, 7, b0);
    chk("flush_shift_primed", {63'd0, primed}, 64'd0);
    run_check("fl_c", 16'h0007, 16'h0000, 16'h0000, 1'b0, -1, b0);

    // Reset at beat 7 aborts the frame
    do_accept(16'h00AA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_idx == 4'd7) && n < 20);
    chk("rst_reach_beat7", {out_valid, out_idx}, {1'b1, 4'd7});
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_abort", {out_valid, s_ready}, {1'b0, 1'b0});
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_release", {s_ready, out_valid, primed}, {1'b1, 1'b0, 1'b0});
    run_check("rst_next", 16'h0009, 16'h0000, 16'h0000, 1'b0, -1, b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_serializer.md
FIR_TAP_SERIALIZER -- requirements
Module: fir_tap_serializer

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits, two's complement; legal range 2..32.
REQ-002 Parameter TAPS, default 64: delay-line depth; must be a multiple of GROUP.
REQ-003 Parameter GROUP, default 8: taps per DA lane; out_bits is laid out as TAPS/GROUP lanes of GROUP bits.
REQ-004 Parameter MSB_FIRST, default 0: 0 = bit 0 emitted first; 1 = bit DATA_W-1 emitted first.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  clears the delay line and warm-up count.
REQ-008 s_valid  input  1  new sample offered.
REQ-009 s_data  input  DATA_W  sample value.
REQ-010 s_ready  output  1  sample accepted when s_valid && s_ready.
REQ-011 out_ready  input  1  downstream accepts the current bit beat.
REQ-012 out_valid  output  1  out_bits holds a valid bit slice.
REQ-013 out_bits  output  TAPS  bit k = selected bit of tap k; lane g = bits [g*GROUP +: GROUP].
REQ-014 out_idx  output  clog2(DATA_W)  index of the sample bit currently on out_bits.
REQ-015 out_first / out_last  output  1 each  first / final beat of a frame.
REQ-016 primed  output  1  high once at least TAPS samples have been accepted since reset or flush.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SHIFT; s_ready = (state==IDLE) && !flush.
REQ-018 On acceptance: tap[0] <= s_data, tap[k] <= tap[k-1] for k=1..TAPS-1; tap[TAPS-1] is discarded; state -> LOAD.
REQ-019 LOAD (one cycle): snapshot[k] <= tap[k] for all k; beat counter <= 0; state -> SHIFT.
REQ-020 In SHIFT, out_valid=1; out_bits[k] = snapshot[k][out_idx]; out_idx = beat (MSB_FIRST=0) or DATA_W-1-beat (MSB_FIRST=1).
REQ-021 A beat completes only on out_valid && out_ready; when out_ready is low, out_bits, out_idx, out_first and out_last SHALL hold.
REQ-022 out_first = (beat==0) in SHIFT; out_last = (beat==DATA_W-1) in SHIFT; otherwise both 0.
REQ-023 Completion of the last beat SHALL return to IDLE; s_ready rises the following cycle.
REQ-024 Latency: a sample accepted in cycle N SHALL produce its first beat (out_valid=1) in cycle N+2; a frame with no stall occupies DATA_W+2 cycles from acceptance to the next s_ready.
REQ-025 Delay-line contents SHALL change only on acceptance or flush; snapshot SHALL change only in LOAD.
REQ-026 Warm-up counter SHALL saturate at TAPS; primed = (count==TAPS); it increments on each acceptance.
REQ-027 flush in IDLE: all taps <= 0 and count <= 0 in that cycle; any concurrent s_valid is not accepted.
REQ-028 flush in LOAD or SHIFT: the frame in flight SHALL complete from its snapshot unchanged; taps and count clear in the same cycle.
REQ-029 While out_valid=0, out_bits, out_idx, out_first and out_last SHALL be 0.

Reset
REQ-030 With resetn low at a clock edge: state=IDLE, all taps, snapshot, beat and count =0; out_valid=0, primed=0; s_ready=0 while resetn is low.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further beats; the first cycle after release has s_ready=1 and out_valid=0.

Verification
REQ-032 Default parameters, single sample 0x8001, out_ready=1 -> beats at N+2..N+17; out_bits[0]=1 at idx 0 and idx 15, 0 elsewhere; out_bits[63:1]=0; out_first at idx 0, out_last at idx 15.
REQ-033 Feed 64 samples 1..64 -> primed rises on the 64th acceptance; in the 64th frame, at beat idx 0, out_bits[k] = LSB of (64-k).
REQ-034 Hold out_ready low for 5 cycles at beat 3 -> outputs frozen, beat 4 appears only after out_ready returns; s_valid offered throughout is not accepted until the frame ends.
REQ-035 MSB_FIRST=1, DATA_W=8, TAPS=16, GROUP=4, sample 0x80 -> first beat idx 7 with out_bits[0]=1; beats idx 6..0 have out_bits=0.
REQ-036 flush with s_valid in IDLE, then a flush during SHIFT -> first sample dropped; in-flight frame completes unchanged; afterwards all taps are 0 and primed=0.
REQ-037 Reset pulsed at beat 7 -> out_valid=0 in the next cycle; after release s_ready=1 and the next frame shows only the new sample in tap 0.
